// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit line encoder: SYNC, LSB-first serialisation, bit stuffing, NRZI and EOP.
// Define USB_TX_CRC16_EN to append a complemented CRC16 (over all bytes after the PID) before EOP.
module usb_tx_encoder #(
  parameter int         CLKS_PER_BIT = 8,
  parameter logic [7:0] SYNC_BYTE    = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SYNC    = 3'd1,
    S_DATA    = 3'd2,
`ifdef USB_TX_CRC16_EN
    S_CRC     = 3'd3,
`endif
    S_EOP_SE0 = 3'd4,
    S_EOP_J   = 3'd5
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [15:0]   shreg_r;
  logic [3:0]    bit_idx_r;
  logic [2:0]    ones_r;
  logic          last_byte_r;
  logic          lvl_r;

  logic roll_s;
  logic in_ser_s;
  logic stuff_due_s;
  logic bit_last_s;
  logic byte_end_s;
  logic load_pt_s;
  logic accept_s;
  logic underrun_s;
  logic send_en_s;
  logic send_bit_s;
  logic lvl_nxt_s;
  logic dp_nxt_s;
  logic dm_nxt_s;

`ifdef USB_TX_CRC16_EN
  logic [15:0] crc_r;

  // Reflected CRC16 (poly 0x8005) over one byte, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ 16'hA001;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Bit-boundary decode and next-state selection
  always_comb begin
    roll_s = (cnt_r == CNT_MAX);
    case (state_r)
      S_SYNC, S_DATA: in_ser_s = 1'b1;
`ifdef USB_TX_CRC16_EN
      S_CRC:          in_ser_s = 1'b1;
`endif
      default:        in_ser_s = 1'b0;
    endcase
    // SYNC is never stuffed; stuffing only applies to data and CRC bits
    stuff_due_s = in_ser_s && (state_r != S_SYNC) && (ones_r >= 3'd6);
    bit_last_s  = (bit_idx_r == 4'd7);
`ifdef USB_TX_CRC16_EN
    if (state_r == S_CRC) begin
      bit_last_s = (bit_idx_r == 4'd15);
    end else begin
      bit_last_s = (bit_idx_r == 4'd7);
    end
`endif
    byte_end_s = in_ser_s && roll_s && bit_last_s && !stuff_due_s;
    load_pt_s  = byte_end_s && ((state_r == S_SYNC) || ((state_r == S_DATA) && !last_byte_r));
    accept_s   = load_pt_s && tx_valid;
    underrun_s = load_pt_s && !tx_valid;

    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (tx_valid) begin
          state_nxt_s = S_SYNC;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_SYNC, S_DATA: begin
        if (accept_s) begin
          state_nxt_s = S_DATA;
        end else if (underrun_s) begin
          state_nxt_s = S_EOP_SE0;
        end else if (byte_end_s) begin
`ifdef USB_TX_CRC16_EN
          state_nxt_s = S_CRC;
`else
          state_nxt_s = S_EOP_SE0;
`endif
        end else begin
          state_nxt_s = state_r;
        end
      end
`ifdef USB_TX_CRC16_EN
      S_CRC: begin
        if (byte_end_s) begin
          state_nxt_s = S_EOP_SE0;
        end else begin
          state_nxt_s = S_CRC;
        end
      end
`endif
      S_EOP_SE0: begin
        if (roll_s && (bit_idx_r == 4'd1)) begin
          state_nxt_s = S_EOP_J;
        end else begin
          state_nxt_s = S_EOP_SE0;
        end
      end
      S_EOP_J: begin
        if (roll_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_EOP_J;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Handshake, next line bit and NRZI/line-state selection
  always_comb begin
    tx_ready   = load_pt_s;
    send_en_s  = 1'b0;
    send_bit_s = 1'b0;
    if (state_r == S_IDLE) begin
      send_en_s  = tx_valid;
      send_bit_s = SYNC_BYTE[0];
    end else if (in_ser_s && roll_s) begin
      if (stuff_due_s) begin
        send_en_s  = 1'b1;
        send_bit_s = 1'b0;
      end else if (!bit_last_s) begin
        send_en_s  = 1'b1;
        send_bit_s = shreg_r[bit_idx_r + 4'd1];
      end else if (accept_s) begin
        send_en_s  = 1'b1;
        send_bit_s = tx_data[0];
`ifdef USB_TX_CRC16_EN
      end else if ((state_r == S_DATA) && (state_nxt_s == S_CRC)) begin
        send_en_s  = 1'b1;
        send_bit_s = ~crc_r[0];
`endif
      end else begin
        send_en_s  = 1'b0;
        send_bit_s = 1'b0;
      end
    end else begin
      send_en_s  = 1'b0;
      send_bit_s = 1'b0;
    end

    lvl_nxt_s = lvl_r;
    dp_nxt_s  = d_plus;
    dm_nxt_s  = d_minus;
    if (send_en_s) begin
      lvl_nxt_s = send_bit_s ? lvl_r : ~lvl_r;
      dp_nxt_s  = lvl_nxt_s;
      dm_nxt_s  = ~lvl_nxt_s;
    end else if (state_nxt_s == S_EOP_SE0) begin
      lvl_nxt_s = 1'b1;
      dp_nxt_s  = 1'b0;
      dm_nxt_s  = 1'b0;
    end else if ((state_nxt_s == S_EOP_J) || (state_nxt_s == S_IDLE)) begin
      lvl_nxt_s = 1'b1;
      dp_nxt_s  = 1'b1;
      dm_nxt_s  = 1'b0;
    end else begin
      lvl_nxt_s = lvl_r;
      dp_nxt_s  = d_plus;
      dm_nxt_s  = d_minus;
    end
  end

  // Bit timing, shift register, stuffing counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= {CW{1'b0}};
      shreg_r     <= 16'h0000;
      bit_idx_r   <= 4'd0;
      ones_r      <= 3'd0;
      last_byte_r <= 1'b0;
      lvl_r       <= 1'b1;
      d_plus      <= 1'b1;
      d_minus     <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
    end else begin
      if ((state_r == S_IDLE) || roll_s) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end
      lvl_r   <= lvl_nxt_s;
      d_plus  <= dp_nxt_s;
      d_minus <= dm_nxt_s;
      tx_busy <= (state_nxt_s != S_IDLE);
      tx_done <= (state_r == S_EOP_J) && (state_nxt_s == S_IDLE);
      tx_err  <= underrun_s;

      // Run of ones restarts from zero at the start of every packet
      if (send_en_s && send_bit_s) begin
        if (state_r == S_IDLE) begin
          ones_r <= 3'd1;
        end else if (ones_r != 3'd7) begin
          ones_r <= ones_r + 3'd1;
        end else begin
          ones_r <= ones_r;
        end
      end else if (send_en_s || (state_r == S_IDLE)) begin
        ones_r <= 3'd0;
      end else begin
        ones_r <= ones_r;
      end

      if (state_r == S_IDLE) begin
        bit_idx_r <= 4'd0;
      end else if (roll_s) begin
        if (stuff_due_s) begin
          bit_idx_r <= bit_idx_r;
        end else if ((in_ser_s && bit_last_s) || (state_nxt_s != state_r)) begin
          bit_idx_r <= 4'd0;
        end else begin
          bit_idx_r <= bit_idx_r + 4'd1;
        end
      end else begin
        bit_idx_r <= bit_idx_r;
      end

      if (state_r == S_IDLE) begin
        shreg_r     <= {8'h00, SYNC_BYTE};
        last_byte_r <= 1'b0;
      end else if (accept_s) begin
        shreg_r     <= {8'h00, tx_data};
        last_byte_r <= tx_last;
`ifdef USB_TX_CRC16_EN
      end else if ((state_r == S_DATA) && (state_nxt_s == S_CRC)) begin
        shreg_r     <= ~crc_r;
        last_byte_r <= last_byte_r;
`endif
      end else begin
        shreg_r     <= shreg_r;
        last_byte_r <= last_byte_r;
      end
    end
  end

`ifdef USB_TX_CRC16_EN
  // CRC accumulates every accepted byte except the PID
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_r <= 16'hFFFF;
    end else if (state_r == S_IDLE) begin
      crc_r <= 16'hFFFF;
    end else if (accept_s && (state_r == S_DATA)) begin
      crc_r <= crc16_byte(crc_r, tx_data);
    end else begin
      crc_r <= crc_r;
    end
  end
`endif

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Self-checking bench for usb_tx_encoder: directed and random packets compared cycle by cycle
// against a bit-stream reference model (SYNC, stuffing, optional CRC16, NRZI, EOP).
module tb_usb_tx_encoder;
  localparam int         CPB  = 8;
  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       d_plus;
  logic       d_minus;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] pkt [0:7];
  int         pkt_n;
  bit         pkt_under;
  logic       bits_q [$];
  logic [1:0] sym_q [$];
  int         loads_q [$];
  int         err_bit;

  usb_tx_encoder #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'h80)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .d_plus(d_plus), .d_minus(d_minus),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s {dp,dm,ready,busy,done,err} observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  // Data/CRC bit with stuffing: a 0 follows every sixth consecutive 1
  task automatic add_bit(input logic b, inout int run);
    bits_q.push_back(b);
    if (b) begin
      run++;
      if (run == 6) begin
        bits_q.push_back(1'b0);
        run = 0;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic build_model();
    int run;
    logic lvl;
    logic [7:0] sb;
`ifdef USB_TX_CRC16_EN
    logic [15:0] crc;
    logic fb;
`endif
    bits_q.delete(); sym_q.delete(); loads_q.delete();
    sb = 8'h80;
    run = 0;
    for (int i = 0; i < 8; i++) begin
      bits_q.push_back(sb[i]);
      run = sb[i] ? run + 1 : 0;
    end
    loads_q.push_back(bits_q.size() - 1);
    for (int k = 0; k < pkt_n; k++) begin
      for (int i = 0; i < 8; i++) add_bit(pkt[k][i], run);
      if ((k < pkt_n - 1) || pkt_under) loads_q.push_back(bits_q.size() - 1);
    end
    err_bit = pkt_under ? bits_q.size() - 1 : -1;
`ifdef USB_TX_CRC16_EN
    if (!pkt_under) begin
      // Serial-register form: MSB-first register, sent complemented starting at bit 15
      crc = 16'hFFFF;
      for (int k = 1; k < pkt_n; k++) begin
        for (int i = 0; i < 8; i++) begin
          fb  = pkt[k][i] ^ crc[15];
          crc = {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
      end
      crc = ~crc;
      for (int i = 15; i >= 0; i--) add_bit(crc[i], run);
    end
`endif
    lvl = 1'b1;
    foreach (bits_q[i]) begin
      if (bits_q[i] == 1'b0) lvl = ~lvl;
      sym_q.push_back(lvl ? LJ : LK);
    end
    sym_q.push_back(LSE0);
    sym_q.push_back(LSE0);
    sym_q.push_back(LJ);
  endtask

  // Starts between clock edges with the DUT idle; returns at the falling edge of the tx_done cycle
  task automatic run_packet(input string tag);
    int idx;
    int total;
    bit acc;
    bit is_load;
    logic [5:0] exp_v;
    build_model();
    total    = sym_q.size() * CPB;
    idx      = 0;
    tx_valid = 1'b1;
    tx_data  = pkt[0];
    tx_last  = (pkt_n == 1) && !pkt_under;
    @(posedge clk);
    for (int j = 0; j <= total; j++) begin
      @(negedge clk);
      if (j == total) begin
        exp_v = {LJ, 1'b0, 1'b0, 1'b1, 1'b0};
      end else begin
        is_load = 1'b0;
        foreach (loads_q[q]) if ((j % CPB == CPB - 1) && (loads_q[q] == j / CPB)) is_load = 1'b1;
        exp_v = {sym_q[j / CPB], is_load, 1'b1, 1'b0, (err_bit >= 0) && (j == (err_bit + 1) * CPB)};
      end
      check(tag, {d_plus, d_minus, tx_ready, tx_busy, tx_done, tx_err}, exp_v);
      acc = tx_valid && tx_ready;
      if (j == total) break;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < pkt_n) begin
          tx_data = pkt[idx];
          tx_last = (idx == pkt_n - 1) && !pkt_under;
        end else begin
          tx_valid = 1'b0;
          tx_last  = 1'b0;
          tx_data  = 8'($urandom);
        end
      end
    end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    repeat (n) begin
      @(negedge clk);
      check(tag, {d_plus, d_minus, tx_ready, tx_busy, tx_done, tx_err}, {LJ, 4'b0000});
    end
  endtask

  initial begin
    rst = 1'b1; tx_valid = 1'b0; tx_last = 1'b0; tx_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", {d_plus, d_minus, tx_ready, tx_busy, tx_done, tx_err}, {LJ, 4'b0000});
    rst = 1'b0;
    idle_cycles(5, "idle_after_reset");

    pkt[0] = 8'hC3; pkt_n = 1; pkt_under = 1'b0;
    run_packet("single_c3");
    idle_cycles(3, "idle_1");

    pkt[0] = 8'hFF; pkt[1] = 8'hFF; pkt_n = 2; pkt_under = 1'b0;
    run_packet("stuff_ff_ff");
    idle_cycles(3, "idle_2");

    pkt[0] = 8'hA5; pkt[1] = 8'h5A; pkt_n = 2; pkt_under = 1'b0;
    run_packet("handshake_a5_5a");
    idle_cycles(2, "idle_3");

    pkt[0] = 8'h69; pkt_n = 1; pkt_under = 1'b1;
    run_packet("underrun_69");
    idle_cycles(2, "idle_4");

    pkt[0] = 8'h4B; pkt_n = 1; pkt_under = 1'b0;
    run_packet("crc_4b");

    pkt[0] = 8'h3C; pkt_n = 1; pkt_under = 1'b0;
    run_packet("b2b_first");
    pkt[0] = 8'h96; pkt[1] = 8'h00; pkt[2] = 8'h7E; pkt_n = 3; pkt_under = 1'b0;
    run_packet("b2b_second");
    idle_cycles(2, "idle_5");

    for (int r = 0; r < 8; r++) begin
      pkt_n     = $urandom_range(1, 4);
      pkt_under = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < pkt_n; k++) pkt[k] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      run_packet($sformatf("random_%0d", r));
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 4), "idle_random");
    end

    // Reset in the middle of a packet: line back to J with no EOP and no tx_done afterwards
    idle_cycles(1, "idle_6");
    tx_valid = 1'b1; tx_data = 8'hFF; tx_last = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1; tx_valid = 1'b0; tx_last = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_mid_packet", {d_plus, d_minus, tx_ready, tx_busy, tx_done, tx_err}, {LJ, 4'b0000});
    rst = 1'b0;
    idle_cycles(200, "idle_after_mid_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
